// File: rtl/bmp_stream_writer_pkg.sv
// Shared constants, FSM encoding and BMP header byte generator for the streaming writer.
// Header bytes are pure functions of the image geometry, so they fold to a small ROM.
package bmp_pkg;

  localparam int HDR_BYTES   = 54;
  localparam int INFO_SIZE   = 40;
  localparam int PPM         = 2835;
  localparam int PAL_BYTES   = 1024;
  localparam int PAL_ENTRIES = 256;
  localparam int BM_MAGIC    = 16'h4D42;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAL  = 3'd2,
    PIX  = 3'd3,
    PAD  = 3'd4
  } state_t;

  function automatic logic [7:0] hdr_byte(input int unsigned idx, input int unsigned w,
                                          input int unsigned h, input int unsigned ch);
    int unsigned rowb;
    int unsigned pad;
    int unsigned img;
    int unsigned off;
    int unsigned base;
    logic [31:0] val;
    logic [31:0] sh;
    rowb = w * ch;
    pad  = (4 - rowb % 4) % 4;
    img  = (rowb + pad) * h;
    off  = HDR_BYTES + ((ch == 1) ? PAL_BYTES : 0);
    val  = '0;
    // Each field is located by its base offset; 16-bit fields simply never reach their top bytes.
    if (idx < 2) begin
      base = 0;  val = BM_MAGIC;
    end else if (idx < 6) begin
      base = 2;  val = off + img;
    end else if (idx < 10) begin
      base = 6;  val = '0;
    end else if (idx < 14) begin
      base = 10; val = off;
    end else if (idx < 18) begin
      base = 14; val = INFO_SIZE;
    end else if (idx < 22) begin
      base = 18; val = w;
    end else if (idx < 26) begin
      base = 22; val = 32'd0 - h;
    end else if (idx < 28) begin
      base = 26; val = 32'd1;
    end else if (idx < 30) begin
      base = 28; val = ch * 8;
    end else if (idx < 34) begin
      base = 30; val = '0;
    end else if (idx < 38) begin
      base = 34; val = img;
    end else if (idx < 42) begin
      base = 38; val = PPM;
    end else if (idx < 46) begin
      base = 42; val = PPM;
    end else if (idx < 50) begin
      base = 46; val = (ch == 1) ? PAL_ENTRIES : 0;
    end else begin
      base = 50; val = '0;
    end
    sh = val >> (8 * (idx - base));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/bmp_beat_serializer.sv
// One-beat holding register that drains PPB*CH bytes, pixel 0 first, B,G,R (or Y) per pixel.
// First byte the cycle after load; holds while out_ready is low; reloads one cycle after drain.
module bmp_beat_serializer #(
  parameter int PPB = 2,
  parameter int CH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PPB*CH*8-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last
);

  localparam int NB = PPB * CH;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [SW-1:0] SEL_LAST = SW'(NB - 1);

  logic [NB*8-1:0] hold;
  logic [NB*8-1:0] ordered;
  logic            hold_valid;
  logic [SW-1:0]   sel;

  // Reorder at load time so draining is a plain byte index into the holding register.
  always_comb begin
    ordered = '0;
    for (int p = 0; p < PPB; p++) begin
      for (int c = 0; c < CH; c++) begin
        ordered[(p*CH + c)*8 +: 8] = in_data[(p*CH + CH - 1 - c)*8 +: 8];
      end
    end
  end

  assign in_ready  = enable & ~hold_valid;
  assign out_valid = hold_valid;
  assign out_data  = 8'(hold >> {sel, 3'b000});
  assign out_last  = hold_valid & (sel == SEL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      sel        <= '0;
    end else if (in_valid && in_ready) begin
      hold       <= ordered;
      hold_valid <= 1'b1;
      sel        <= '0;
    end else if (hold_valid && out_ready) begin
      if (sel == SEL_LAST) begin
        hold_valid <= 1'b0;
        sel        <= '0;
      end else begin
        sel <= sel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Streams a top-down BMP file (header, optional grey palette, padded pixel rows) as bytes.
// Header/palette/pad bytes are offered every cycle; pixel bytes follow one-beat buffering; out_ready stalls all.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int CH     = 3,
  parameter int PPB    = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PPB*CH*8-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int ROWB    = WIDTH * CH;
  localparam int PAD_N   = (4 - ROWB % 4) % 4;
  localparam bit HAS_PAD = (PAD_N != 0);
  localparam int BEATS   = WIDTH / PPB;
  localparam int FW      = $clog2(PAL_BYTES);
  localparam int BW      = $clog2(BEATS + 1);
  localparam int RW      = $clog2(HEIGHT + 1);

  localparam logic [FW-1:0] HDR_LAST  = FW'(HDR_BYTES - 1);
  localparam logic [FW-1:0] PAL_LAST  = FW'(PAL_BYTES - 1);
  localparam logic [FW-1:0] PAD_LAST  = FW'(HAS_PAD ? PAD_N - 1 : 0);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);

  state_t          state;
  logic [FW-1:0]   fcnt;
  logic [BW-1:0]   col;
  logic [RW-1:0]   row;

  logic            pix_mode;
  logic            ser_valid;
  logic [7:0]      ser_data;
  logic            ser_last;
  logic            gen_valid;
  logic [7:0]      gen_data;
  logic            fire;
  logic            row_end;
  logic            last_row;

  assign pix_mode = (state == PIX);

  bmp_beat_serializer #(
    .PPB (PPB),
    .CH  (CH)
  ) u_ser (
    .clk       (HCLK),
    .rst       (HRESET),
    .enable    (pix_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (ser_valid),
    .out_ready (out_ready),
    .out_data  (ser_data),
    .out_last  (ser_last)
  );

  always_comb begin
    gen_valid = 1'b0;
    gen_data  = 8'h00;
    case (state)
      HDR: begin
        gen_valid = 1'b1;
        gen_data  = hdr_byte(32'(fcnt), WIDTH, HEIGHT, CH);
      end
      PAL: begin
        gen_valid = 1'b1;
        gen_data  = (fcnt[1:0] == 2'd3) ? 8'h00 : fcnt[9:2];
      end
      PAD: gen_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_valid = pix_mode ? ser_valid : gen_valid;
  assign out_data  = pix_mode ? ser_data  : gen_data;
  assign fire      = out_valid & out_ready;
  assign last_row  = (row == ROW_LAST);
  // A row ends on its final pad byte, or on its final pixel byte when rows need no padding.
  assign row_end   = (pix_mode && !HAS_PAD && ser_last && col == BEAT_LAST) ||
                     (state == PAD && fcnt == PAD_LAST);
  assign out_last  = out_valid & row_end & last_row;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      fcnt       <= '0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= HDR;
            busy  <= 1'b1;
          end
        end
        HDR: begin
          if (fire) begin
            if (fcnt == HDR_LAST) begin
              fcnt  <= '0;
              state <= (CH == 1) ? PAL : PIX;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        PAL: begin
          if (fire) begin
            if (fcnt == PAL_LAST) begin
              fcnt  <= '0;
              state <= PIX;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        PIX: begin
          if (fire && ser_last) begin
            if (col == BEAT_LAST) begin
              col <= '0;
              if (HAS_PAD) state <= PAD;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        PAD: begin
          if (fire) begin
            fcnt <= (fcnt == PAD_LAST) ? '0 : fcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Row advance overrides the per-state next state above.
      if (fire && row_end) begin
        if (last_row) begin
          state      <= IDLE;
          row        <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          row   <= row + 1'b1;
          state <= PIX;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Three writer configurations checked against a byte-level BMP file model with random stalls.
module tb_bmp_stream_writer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_dat;
  int          cur;

  logic [2:0]  start_v, inv_v;
  logic [2:0]  in_ready_v, out_valid_v, out_last_v, busy_v, done_v;
  logic [7:0]  out_data_v [3];
  logic        o_in_ready, o_valid, o_last, o_busy, o_done;
  logic [7:0]  o_data;

  int vectors = 0;
  int miscompares = 0;

  int cfg_w   [3] = '{3, 4, 3};
  int cfg_h   [3] = '{2, 3, 2};
  int cfg_ch  [3] = '{3, 3, 1};
  int cfg_ppb [3] = '{1, 2, 1};

  logic [7:0]  exp_q[$];
  logic [7:0]  got[$];
  logic [47:0] beats[$];
  int          fsize;

  always #5 HCLK = ~HCLK;

  always_comb begin
    start_v = '0;
    inv_v   = '0;
    start_v[cur] = start;
    inv_v[cur]   = in_valid;
    o_in_ready = in_ready_v[cur];
    o_valid    = out_valid_v[cur];
    o_last     = out_last_v[cur];
    o_busy     = busy_v[cur];
    o_done     = done_v[cur];
    o_data     = out_data_v[cur];
  end

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .CH(3), .PPB(1)) u_a (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_v[0]), .in_valid(inv_v[0]),
    .in_ready(in_ready_v[0]), .in_data(in_dat[23:0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(out_data_v[0]), .out_last(out_last_v[0]),
    .busy(busy_v[0]), .frame_done(done_v[0]));

  bmp_stream_writer #(.WIDTH(4), .HEIGHT(3), .CH(3), .PPB(2)) u_b (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_v[1]), .in_valid(inv_v[1]),
    .in_ready(in_ready_v[1]), .in_data(in_dat[47:0]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(out_data_v[1]), .out_last(out_last_v[1]),
    .busy(busy_v[1]), .frame_done(done_v[1]));

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .CH(1), .PPB(1)) u_c (
    .HCLK(HCLK), .HRESET(HRESET), .start(start_v[2]), .in_valid(inv_v[2]),
    .in_ready(in_ready_v[2]), .in_data(in_dat[7:0]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(out_data_v[2]), .out_last(out_last_v[2]),
    .busy(busy_v[2]), .frame_done(done_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_le(input logic [31:0] v, input int nb);
    for (int i = 0; i < nb; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  function automatic logic [31:0] le32(input int i);
    return {got[i+3], got[i+2], got[i+1], got[i]};
  endfunction

  // Appends one complete expected file plus the matching input beats for configuration k.
  task automatic model_file(input int k);
    int w, h, ch, ppb, rowb, pad, img, off;
    logic [23:0] pix[$];
    logic [23:0] px;
    logic [47:0] beat;
    w = cfg_w[k]; h = cfg_h[k]; ch = cfg_ch[k]; ppb = cfg_ppb[k];
    rowb = w * ch;
    pad  = (4 - rowb % 4) % 4;
    img  = (rowb + pad) * h;
    off  = 54 + ((ch == 1) ? 1024 : 0);
    fsize = off + img;
    for (int i = 0; i < w * h; i++)
      pix.push_back((i == 0) ? 24'h332211 : (i == 1) ? 24'h665544 : 24'($urandom));
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    push_le(32'(fsize), 4); push_le(0, 4); push_le(32'(off), 4);
    push_le(40, 4); push_le(32'(w), 4); push_le(32'(-h), 4);
    push_le(1, 2); push_le(32'(ch * 8), 2); push_le(0, 4); push_le(32'(img), 4);
    push_le(2835, 4); push_le(2835, 4);
    push_le((ch == 1) ? 256 : 0, 4); push_le(0, 4);
    if (ch == 1)
      for (int i = 0; i < 256; i++) begin
        exp_q.push_back(8'(i)); exp_q.push_back(8'(i)); exp_q.push_back(8'(i)); exp_q.push_back(8'h00);
      end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = pix[r*w + c];
        if (ch == 3) begin
          exp_q.push_back(px[23:16]); exp_q.push_back(px[15:8]); exp_q.push_back(px[7:0]);
        end else begin
          exp_q.push_back(px[7:0]);
        end
      end
      for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
    end
    for (int b = 0; b < w * h / ppb; b++) begin
      beat = '0;
      for (int p = 0; p < ppb; p++) begin
        px = pix[b*ppb + p];
        if (ch == 3) beat[p*24 +: 24] = px;
        else         beat[p*8 +: 8]   = px[7:0];
      end
      beats.push_back(beat);
    end
  endtask

  task automatic run(input int k, input int nfiles, input int stall_pct, input int gap_max,
                     input bit extra_start, input int reset_at);
    int n, beat_i, gap, cycles, ndone, total, budget;
    bit prev_stall, stop;
    logic [7:0] prev_dat;
    cur = k;
    got.delete(); exp_q.delete(); beats.delete();
    for (int f = 0; f < nfiles; f++) model_file(k);
    total  = exp_q.size();
    budget = total * 6 + 500;
    n = 0; beat_i = 0; gap = 0; cycles = 0; ndone = 0;
    prev_stall = 0; stop = 0; prev_dat = '0;
    while (n < total && cycles < budget && !stop) begin
      @(posedge HCLK); #1;
      start     = (cycles == 0) || (extra_start && o_busy && $urandom_range(7) == 0);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (beat_i < beats.size() && gap == 0) begin
        in_valid = 1'b1;
        in_dat   = beats[beat_i];
      end else begin
        in_valid = 1'b0;
        if (gap > 0) gap--;
      end
      @(negedge HCLK);
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_dat);
      end
      prev_stall = o_valid & ~out_ready;
      prev_dat   = o_data;
      if (in_valid && o_in_ready) begin
        beat_i++;
        gap = $urandom_range(gap_max);
      end
      if (o_valid && out_ready) begin
        chk("byte", o_data, exp_q[n]);
        chk("last", o_last, 32'((n + 1) % fsize == 0));
        got.push_back(o_data);
        n++;
      end
      if (o_done) begin
        ndone++;
        if (ndone < nfiles) start = 1'b1;
      end
      if (reset_at > 0 && n == reset_at) stop = 1;
      cycles++;
    end
    if (stop) begin
      @(posedge HCLK); #1;
      HRESET = 1'b1; in_valid = 1'b0; start = 1'b0;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      chk("rst_out_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_in_ready", o_in_ready, 0);
    end else begin
      chk("timeout_bytes", n, total);
      for (int i = 0; i < 3; i++) begin
        @(posedge HCLK); #1;
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        @(negedge HCLK);
        if (o_done) ndone++;
      end
      chk("frame_done_count", ndone, nfiles);
      chk("busy_end", o_busy, 0);
      chk("beats_used", beat_i, beats.size());
    end
  endtask

  initial begin
    HRESET = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_dat = '0; cur = 0;
    repeat (3) @(posedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      #1;
      chk("reset_in_ready", o_in_ready, 0);
      chk("reset_out_valid", o_valid, 0);
      chk("reset_out_last", o_last, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_frame_done", o_done, 0);
      chk("reset_out_data", o_data, 0);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    run(0, 1, 0, 0, 0, 0);
    chk("a_bfsize", le32(2), 32'h0000004E);
    chk("a_offbits", le32(10), 32'h00000036);
    chk("a_height", le32(22), 32'hFFFFFFFE);
    chk("a_sizeimage", le32(34), 32'h00000018);
    chk("a_pix0", {got[54], got[55], got[56]}, 32'h332211);
    chk("a_row_pad", {got[63], got[64], got[65]}, 32'h0);
    run(0, 1, 30, 3, 1, 0);

    run(1, 1, 0, 0, 0, 0);
    chk("b_pix_order", {got[54], got[55], got[56], got[57]}, 32'h33221166);
    chk("b_pix1_tail", {got[58], got[59]}, 32'h5544);
    run(1, 1, 30, 3, 1, 0);

    run(2, 1, 0, 0, 0, 0);
    chk("c_offbits", le32(10), 32'h00000436);
    chk("c_bfsize", le32(2), 32'h0000043E);
    chk("c_bitcount", got[28], 32'h08);
    chk("c_pal5", le32(74), 32'h00050505);
    run(2, 1, 30, 2, 0, 0);

    run(0, 1, 30, 2, 0, 40);
    run(0, 1, 30, 2, 0, 0);

    run(0, 2, 0, 0, 0, 0);
    chk("chain_total", got.size(), 2 * 78);
    chk("chain_second_b", got[78], 32'h42);
    run(1, 2, 30, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bmp_stream_writer.md
Name: bmp_stream_writer

Overview:
- Streaming BMP file serialiser; successor to the simulation-only image writer.
- Accepts a top-down pixel stream (valid/ready) and emits the complete BMP file as a byte stream (valid/ready).
- Byte stream order: generated header, optional grey palette, pixel bytes in B,G,R order, per-row padding to 4 bytes.
- Synthesisable; feeds a UART/SD/DMA byte sink or a bench file-dump monitor. No frame buffer: height is written negative, so the file is a top-down BMP.

Parameters:
- WIDTH, 512, image width in pixels; must be a multiple of PPB.
- HEIGHT, 512, image height in rows.
- CH, 3, bytes per pixel: 3 = RGB888, 24 bpp; 1 = grey, 8 bpp with 256-entry palette.
- PPB, 2, pixels per input beat (1, 2 or 4).

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse: begin a file; ignored while busy=1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  PPB*CH*8  pixel p at [p*CH*8 +: CH*8]; pixel 0 is leftmost. Within a pixel: [7:0]=R, [15:8]=G, [23:16]=B (CH=3); [7:0]=Y (CH=1).
- out_valid  out  1  output byte valid.
- out_ready  in  1  sink accepts byte when out_valid & out_ready.
- out_data  out  8  file byte.
- out_last  out  1  high with the final byte of the file.
- busy  out  1  high from accepted start until final byte accepted.
- frame_done  out  1  one-cycle pulse the cycle after the final byte is accepted.

Behaviour:
- Reset: FSM=IDLE; all counters 0; in_ready, out_valid, out_last, busy, frame_done all 0; out_data 0. Reset mid-file abandons the file immediately; no partial-state carry-over.
- Derived constants (elaboration time):
  - ROWB = WIDTH*CH.
  - PAD = (4 - ROWB%4)%4.
  - IMG = (ROWB+PAD)*HEIGHT.
  - OFF = 54 + (CH==1 ? 1024 : 0).
  - FSIZE = OFF + IMG.
  - All header fields are 32-bit little-endian unless noted.
- FSM states and transitions:
  - IDLE: start -> HDR, next cycle.
  - HDR: 54 bytes, index 0..53 -> PAL if CH==1, else PIX.
  - PAL: 1024 bytes; byte j = (j%4==3) ? 0 : j/4 -> PIX.
  - PIX: emit pixel bytes of current row -> PAD if PAD!=0, else next row.
  - PAD: PAD zero bytes -> next row.
  - After the last row's last byte accepted -> IDLE, pulse frame_done.
- Header contents:
  - 'B','M'.
  - bfSize=FSIZE; reserved 0; bfOffBits=OFF.
  - biSize=40; biWidth=WIDTH; biHeight = -HEIGHT (two's complement, 32 bit).
  - biPlanes=1 (16 bit); biBitCount=CH*8 (16 bit); biCompression=0; biSizeImage=IMG.
  - XPelsPerMeter=2835; YPelsPerMeter=2835.
  - biClrUsed = (CH==1 ? 256 : 0); biClrImportant=0.
- Output handshake:
  - out_data/out_last held stable while out_valid & !out_ready.
  - Counters advance only on an accepted byte.
  - out_valid high continuously in HDR/PAL/PAD; in PIX only while a beat is held.
- Input path:
  - One-beat holding register. in_ready = (state==PIX) & !hold_valid.
  - A beat drains in PPB*CH accepted output bytes, pixel 0 first; per pixel B,G,R (or Y).
  - hold_valid clears on acceptance of the beat's last byte.
  - One bubble cycle per beat (in_ready rises the cycle after drain); max throughput PPB*CH bytes per PPB*CH+1 cycles.
  - Latency: accepted beat -> first byte on out_data the next cycle.
- Row handling: WIDTH/PPB beats per row. After the last beat of a row drains, in_ready stays low through PAD.
- Boundaries:
  - in_valid outside PIX is ignored (in_ready=0, no side effect).
  - start while busy is ignored.
  - start in the same cycle as frame_done is accepted (IDLE is entered that cycle).
  - out_ready low indefinitely: stalls all progress without loss.
- Counters:
  - byte-in-field: width $clog2(1024).
  - column beat: $clog2(WIDTH/PPB+1).
  - row: $clog2(HEIGHT+1).
  - All wrap to 0 on state exit.

Decomposition:
- Package bmp_pkg:
  - Header byte offsets and field constants (54, 40, 2835, 1024).
  - FSM state enum {IDLE,HDR,PAL,PIX,PAD}.
  - Function hdr_byte(idx, WIDTH, HEIGHT, CH) returning the header byte.
- One sub-module, bmp_beat_serializer: holding register plus byte-select counter, PPB*CH bytes out with valid/ready. Top level holds the FSM, header/palette/pad generation and output mux.

Test Plan:
- WIDTH=3, HEIGHT=2, CH=3, PPB=1, out_ready=1:
  - bytes 2..5 = 4E 00 00 00 (FSIZE 78); bytes 10..13 = 36 00 00 00.
  - bytes 22..25 = FE FF FF FF; bytes 34..37 = 18 00 00 00.
  - Each row is 9 pixel bytes then 00 00 00; out_last on byte 77; frame_done pulses once.
- Same config, pixel R=11,G=22,B=33 -> output 33 22 11. With PPB=2: pixel 0 bytes precede pixel 1 bytes.
- WIDTH=3, HEIGHT=2, CH=1:
  - bfOffBits = 36 04 00 00; bfSize = 3E 04 00 00; bitcount byte 28 = 08.
  - Palette byte 54+4*5 .. +3 = 05 05 05 00.
  - Rows = 3 Y bytes + 00.
- Random out_ready (30% low) and random in_valid gaps: byte stream identical to stall-free golden; out_data stable across every stall.
- Extra start pulses mid-file are ignored. HRESET asserted at byte 40: next cycle out_valid=0, busy=0. Fresh start then produces a complete, correct file.
- start asserted in the frame_done cycle: second file begins with 'B' (0x42); total bytes = 2*FSIZE.
